// File: rtl/riscv_decode_queue_if.sv
// Fetch-side and issue-side handshake bundle of the decode queue.
// The queue itself connects through the slave modport; fetch and the issue targets use master.
interface riscv_decode_queue_if;
    logic        fetch_valid_i;
    logic [31:0] fetch_instr_i;
    logic [31:0] fetch_pc_i;
    logic        fetch_accept_o;
    logic        issue_valid_o;
    logic        issue_accept_i;
    logic [31:0] issue_instr_o;
    logic [31:0] issue_pc_o;
    logic [1:0]  issue_unit_o;
    logic        issue_illegal_o;
    logic [4:0]  issue_rd_idx_o;
    logic [4:0]  issue_ra_idx_o;
    logic [4:0]  issue_rb_idx_o;

    modport slave (
        input  fetch_valid_i, fetch_instr_i, fetch_pc_i, issue_accept_i,
        output fetch_accept_o, issue_valid_o, issue_instr_o, issue_pc_o,
        output issue_unit_o, issue_illegal_o, issue_rd_idx_o, issue_ra_idx_o, issue_rb_idx_o
    );

    modport master (
        output fetch_valid_i, fetch_instr_i, fetch_pc_i, issue_accept_i,
        input  fetch_accept_o, issue_valid_o, issue_instr_o, issue_pc_o,
        input  issue_unit_o, issue_illegal_o, issue_rd_idx_o, issue_ra_idx_o, issue_rb_idx_o
    );
endinterface

// File: rtl/riscv_decode_queue.sv
// Pre-decoding instruction queue between fetch and the execution units, with a
// register scoreboard that stalls the head on RAW/WAW hazards and a branch flush.
module riscv_decode_queue #(
    parameter int DEPTH          = 2,
    parameter bit SUPPORT_MULDIV = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    riscv_decode_queue_if.slave          q_if,
    input  logic                         flush_i,
    input  logic                         wb_valid_i,
    input  logic [4:0]                   wb_idx_i,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] UNIT_EXEC   = 2'd0;
    localparam logic [1:0] UNIT_LSU    = 2'd1;
    localparam logic [1:0] UNIT_CSR    = 2'd2;
    localparam logic [1:0] UNIT_MULDIV = 2'd3;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  unit;
        logic        illegal;
        logic        uses_ra;
        logic        uses_rb;
        logic        writes_rd;
    } entry_t;

    entry_t             queue_mem [DEPTH];
    logic [PTR_W-1:0]   head_reg, tail_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [31:0]        busy_reg, busy_next;
    logic [31:0]        sb_set, sb_clr;

    entry_t             push_entry, head_entry;
    logic               empty, hazard, issue_valid, fetch_accept;
    logic               push_fire, pop_fire;
    logic [6:0]         push_opcode;
    logic [4:0]         head_ra, head_rb, head_rd;

    // Pre-decode happens once, on the way into the queue.
    assign push_opcode = q_if.fetch_instr_i[6:0];

    always_comb begin
        push_entry           = '0;
        push_entry.instr     = q_if.fetch_instr_i;
        push_entry.pc        = q_if.fetch_pc_i;
        push_entry.unit      = UNIT_CSR;
        push_entry.illegal   = 1'b1;
        if (q_if.fetch_instr_i[1:0] == 2'b11) begin
            case (push_opcode)
                OPC_OP: begin
                    if (q_if.fetch_instr_i[31:25] == 7'b0000001) begin
                        if (SUPPORT_MULDIV) begin
                            push_entry.unit    = UNIT_MULDIV;
                            push_entry.illegal = 1'b0;
                        end
                    end else begin
                        push_entry.unit    = UNIT_EXEC;
                        push_entry.illegal = 1'b0;
                    end
                end
                OPC_OP_IMM, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: begin
                    push_entry.unit    = UNIT_EXEC;
                    push_entry.illegal = 1'b0;
                end
                OPC_LOAD, OPC_STORE: begin
                    push_entry.unit    = UNIT_LSU;
                    push_entry.illegal = 1'b0;
                end
                OPC_SYSTEM: begin
                    push_entry.unit    = UNIT_CSR;
                    push_entry.illegal = 1'b0;
                end
                default: ;
            endcase
        end
        if (!push_entry.illegal) begin
            push_entry.uses_ra   = !(push_opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
            push_entry.uses_rb   = push_opcode inside {OPC_OP, OPC_BRANCH, OPC_STORE};
            push_entry.writes_rd = !(push_opcode inside {OPC_BRANCH, OPC_STORE})
                                   && (q_if.fetch_instr_i[11:7] != 5'd0);
        end
    end

    assign empty        = (count_reg == '0);
    assign fetch_accept = (count_reg != CNT_W'(DEPTH));
    assign head_entry   = queue_mem[head_reg];
    assign head_ra      = head_entry.instr[19:15];
    assign head_rb      = head_entry.instr[24:20];
    assign head_rd      = head_entry.instr[11:7];

    assign hazard = (head_entry.uses_ra && (head_ra != 5'd0) && busy_reg[head_ra])
                 || (head_entry.uses_rb && (head_rb != 5'd0) && busy_reg[head_rb])
                 || (head_entry.writes_rd && busy_reg[head_rd]);

    assign issue_valid = !empty && !hazard;
    assign push_fire   = q_if.fetch_valid_i && fetch_accept && !flush_i;
    assign pop_fire    = issue_valid && q_if.issue_accept_i && !flush_i;

    assign q_if.fetch_accept_o  = fetch_accept;
    assign q_if.issue_valid_o   = issue_valid;
    assign q_if.issue_instr_o   = empty ? 32'd0 : head_entry.instr;
    assign q_if.issue_pc_o      = empty ? 32'd0 : head_entry.pc;
    assign q_if.issue_unit_o    = empty ? 2'd0  : head_entry.unit;
    assign q_if.issue_illegal_o = empty ? 1'b0  : head_entry.illegal;
    assign q_if.issue_rd_idx_o  = empty ? 5'd0  : head_rd;
    assign q_if.issue_ra_idx_o  = empty ? 5'd0  : head_ra;
    assign q_if.issue_rb_idx_o  = empty ? 5'd0  : head_rb;
    assign occupancy_o          = count_reg;

    always_ff @(posedge clk_i) begin
        if (push_fire) begin
            queue_mem[tail_reg] <= push_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push_fire) tail_reg <= tail_reg + PTR_W'(1);
            if (pop_fire)  head_reg <= head_reg + PTR_W'(1);
            case ({push_fire, pop_fire})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // writes_rd is never set for rd=0 and wb to x0 is filtered, so busy[0] stays clear.
    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (pop_fire && head_entry.writes_rd) sb_set[head_rd] = 1'b1;
        if (wb_valid_i && (wb_idx_i != 5'd0)) sb_clr[wb_idx_i] = 1'b1;
    end

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_busy
            // A same-cycle issue claim outranks the writeback release.
            assign busy_next[gi] = sb_set[gi] | (busy_reg[gi] & ~sb_clr[gi]);
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end
endmodule

// File: tb/tb_riscv_decode_queue.sv
// Directed bench for riscv_decode_queue: a DEPTH=4 queue with MULDIV and a
// DEPTH=2 queue without MULDIV, sharing clock, reset, flush and writeback.
module tb_riscv_decode_queue;
    localparam int DEPTH = 4;

    logic       clk_i = 1'b0;
    logic       rst_i, flush_i, wb_valid_i;
    logic [4:0] wb_idx_i;
    logic [2:0] occupancy;
    logic [1:0] occupancy_n;
    int         errors = 0;
    int         checks = 0;

    riscv_decode_queue_if q_if ();
    riscv_decode_queue_if n_if ();

    riscv_decode_queue #(.DEPTH(DEPTH), .SUPPORT_MULDIV(1'b1)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .q_if(q_if), .flush_i(flush_i),
        .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i), .occupancy_o(occupancy)
    );

    riscv_decode_queue #(.DEPTH(2), .SUPPORT_MULDIV(1'b0)) u_dut_nm (
        .clk_i(clk_i), .rst_i(rst_i), .q_if(n_if), .flush_i(flush_i),
        .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i), .occupancy_o(occupancy_n)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] nop(input int k);
        logic [11:0] imm;
        imm = k[11:0];
        return {imm, 20'h00013};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_q(input logic [31:0] instr, input logic [31:0] pc);
        q_if.fetch_valid_i = 1'b1;
        q_if.fetch_instr_i = instr;
        q_if.fetch_pc_i    = pc;
        $display("push instr=%08h pc=%08h occ=%0d", instr, pc, occupancy);
        tick();
        q_if.fetch_valid_i = 1'b0;
    endtask

    task automatic pop_q();
        $display("issue instr=%08h pc=%08h unit=%0d", q_if.issue_instr_o, q_if.issue_pc_o, q_if.issue_unit_o);
        q_if.issue_accept_i = 1'b1;
        tick();
        q_if.issue_accept_i = 1'b0;
    endtask

    task automatic writeback(input logic [4:0] idx);
        wb_valid_i = 1'b1;
        wb_idx_i   = idx;
        tick();
        wb_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        q_if.fetch_valid_i = 1'b1;
        q_if.fetch_instr_i = 32'h00500093;
        tick();
        tick();
        rst_i = 1'b0;
        q_if.fetch_valid_i = 1'b0;
        q_if.fetch_instr_i = 32'd0;
        checks++; if (q_if.issue_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", q_if.issue_valid_o); end
        checks++; if (q_if.fetch_accept_o !== 1'b1) begin errors++; $display("FAIL reset_accept got=%0h exp=1", q_if.fetch_accept_o); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        checks++; if (q_if.issue_instr_o !== 32'd0 || q_if.issue_pc_o !== 32'd0) begin errors++; $display("FAIL reset_data instr=%08h pc=%08h exp=0", q_if.issue_instr_o, q_if.issue_pc_o); end
        checks++; if ({q_if.issue_unit_o, q_if.issue_illegal_o, q_if.issue_rd_idx_o} !== 8'd0) begin errors++; $display("FAIL reset_fields unit=%0d ill=%0d rd=%0d exp=0", q_if.issue_unit_o, q_if.issue_illegal_o, q_if.issue_rd_idx_o); end
        checks++; if (n_if.issue_valid_o !== 1'b0 || n_if.fetch_accept_o !== 1'b1) begin errors++; $display("FAIL reset_nm valid=%0h accept=%0h exp=0/1", n_if.issue_valid_o, n_if.fetch_accept_o); end
    endtask

    task automatic test_basic();
        q_if.fetch_valid_i = 1'b1;
        q_if.fetch_instr_i = 32'h00500093;
        q_if.fetch_pc_i    = 32'h100;
        checks++; if (q_if.issue_valid_o !== 1'b0) begin errors++; $display("FAIL basic_same_cycle got=%0h exp=0", q_if.issue_valid_o); end
        tick();
        q_if.fetch_valid_i = 1'b0;
        checks++; if (q_if.issue_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0h exp=1", q_if.issue_valid_o); end
        checks++; if (q_if.issue_unit_o !== 2'd0 || q_if.issue_illegal_o !== 1'b0) begin errors++; $display("FAIL basic_unit unit=%0d ill=%0d exp=0/0", q_if.issue_unit_o, q_if.issue_illegal_o); end
        checks++; if (q_if.issue_rd_idx_o !== 5'd1 || q_if.issue_ra_idx_o !== 5'd0 || q_if.issue_rb_idx_o !== 5'd5) begin errors++; $display("FAIL basic_idx rd=%0d ra=%0d rb=%0d exp=1/0/5", q_if.issue_rd_idx_o, q_if.issue_ra_idx_o, q_if.issue_rb_idx_o); end
        checks++; if (q_if.issue_pc_o !== 32'h100 || q_if.issue_instr_o !== 32'h00500093) begin errors++; $display("FAIL basic_data pc=%08h instr=%08h exp=100/00500093", q_if.issue_pc_o, q_if.issue_instr_o); end
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL basic_occ1 got=%0d exp=1", occupancy); end
        pop_q();
        checks++; if (occupancy !== 3'd0 || q_if.issue_valid_o !== 1'b0) begin errors++; $display("FAIL basic_drained occ=%0d valid=%0h exp=0/0", occupancy, q_if.issue_valid_o); end
    endtask

    task automatic test_hazard();
        push_q(32'h00108133, 32'h104);   // add x2,x1,x1 behind busy x1
        checks++; if (q_if.issue_valid_o !== 1'b0) begin errors++; $display("FAIL raw_stall got=%0h exp=0", q_if.issue_valid_o); end
        checks++; if (q_if.issue_instr_o !== 32'h00108133 || occupancy !== 3'd1) begin errors++; $display("FAIL raw_head instr=%08h occ=%0d exp=00108133/1", q_if.issue_instr_o, occupancy); end
        wb_valid_i = 1'b1;
        wb_idx_i   = 5'd1;
        checks++; if (q_if.issue_valid_o !== 1'b0) begin errors++; $display("FAIL raw_no_bypass got=%0h exp=0", q_if.issue_valid_o); end
        tick();
        wb_valid_i = 1'b0;
        checks++; if (q_if.issue_valid_o !== 1'b1) begin errors++; $display("FAIL raw_release got=%0h exp=1", q_if.issue_valid_o); end
        checks++; if (q_if.issue_ra_idx_o !== 5'd1 || q_if.issue_rb_idx_o !== 5'd1 || q_if.issue_rd_idx_o !== 5'd2) begin errors++; $display("FAIL raw_idx ra=%0d rb=%0d rd=%0d exp=1/1/2", q_if.issue_ra_idx_o, q_if.issue_rb_idx_o, q_if.issue_rd_idx_o); end
        pop_q();
        push_q(32'h00700113, 32'h108);   // addi x2,x0,7 while x2 busy
        checks++; if (q_if.issue_valid_o !== 1'b0) begin errors++; $display("FAIL waw_stall got=%0h exp=0", q_if.issue_valid_o); end
        writeback(5'd2);
        checks++; if (q_if.issue_valid_o !== 1'b1) begin errors++; $display("FAIL waw_release got=%0h exp=1", q_if.issue_valid_o); end
        pop_q();
        writeback(5'd2);
    endtask

    task automatic test_full_wrap();
        logic exp_acc;
        for (int i = 0; i <= DEPTH; i++) begin
            q_if.fetch_valid_i = 1'b1;
            q_if.fetch_instr_i = nop(i);
            q_if.fetch_pc_i    = 32'h200 + 32'(4 * i);
            exp_acc = (i < DEPTH);
            checks++; if (q_if.fetch_accept_o !== exp_acc) begin errors++; $display("FAIL fill_accept[%0d] got=%0h exp=%0h", i, q_if.fetch_accept_o, exp_acc); end
            if (exp_acc) $display("push instr=%08h pc=%08h occ=%0d", nop(i), 32'h200 + 32'(4 * i), occupancy);
            tick();
        end
        q_if.fetch_valid_i = 1'b0;
        checks++; if (occupancy !== 3'(DEPTH)) begin errors++; $display("FAIL fill_occ got=%0d exp=%0d", occupancy, DEPTH); end
        for (int k = 0; k < DEPTH; k++) begin
            checks++; if (q_if.issue_valid_o !== 1'b1 || q_if.issue_instr_o !== nop(k) || q_if.issue_pc_o !== 32'h200 + 32'(4 * k)) begin errors++; $display("FAIL drain_order[%0d] valid=%0h instr=%08h pc=%08h exp=1/%08h/%08h", k, q_if.issue_valid_o, q_if.issue_instr_o, q_if.issue_pc_o, nop(k), 32'h200 + 32'(4 * k)); end
            pop_q();
        end
        checks++; if (occupancy !== 3'd0 || q_if.issue_valid_o !== 1'b0) begin errors++; $display("FAIL drain_empty occ=%0d valid=%0h exp=0/0", occupancy, q_if.issue_valid_o); end
        // Streaming: one push and one pop per cycle, carrying the pointers round three times.
        q_if.issue_accept_i = 1'b1;
        for (int j = 0; j < 3 * DEPTH; j++) begin
            q_if.fetch_valid_i = 1'b1;
            q_if.fetch_instr_i = nop(16'h40 + j);
            q_if.fetch_pc_i    = 32'h300 + 32'(4 * j);
            if (j == 0) begin
                checks++; if (q_if.issue_valid_o !== 1'b0) begin errors++; $display("FAIL stream_first got=%0h exp=0", q_if.issue_valid_o); end
            end else begin
                checks++; if (q_if.issue_valid_o !== 1'b1 || q_if.issue_instr_o !== nop(16'h40 + j - 1)) begin errors++; $display("FAIL stream_head[%0d] valid=%0h instr=%08h exp=1/%08h", j, q_if.issue_valid_o, q_if.issue_instr_o, nop(16'h40 + j - 1)); end
            end
            $display("stream push=%08h head=%08h", nop(16'h40 + j), q_if.issue_instr_o);
            tick();
            checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL stream_occ[%0d] got=%0d exp=1", j, occupancy); end
        end
        q_if.fetch_valid_i = 1'b0;
        checks++; if (q_if.issue_instr_o !== nop(16'h40 + 3 * DEPTH - 1)) begin errors++; $display("FAIL stream_last got=%08h exp=%08h", q_if.issue_instr_o, nop(16'h40 + 3 * DEPTH - 1)); end
        tick();
        q_if.issue_accept_i = 1'b0;
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL stream_empty got=%0d exp=0", occupancy); end
    endtask

    task automatic test_flush();
        push_q(32'h00500093, 32'h400);
        pop_q();                          // x1 busy
        push_q(32'h00100493, 32'h404);   // addi x9,x0,1
        push_q(nop(16'h77), 32'h408);
        checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL flush_pre_occ got=%0d exp=2", occupancy); end
        flush_i = 1'b1;
        q_if.fetch_valid_i  = 1'b1;
        q_if.fetch_instr_i  = nop(16'h55);
        q_if.fetch_pc_i     = 32'h40C;
        q_if.issue_accept_i = 1'b1;
        $display("flush with push=%08h", nop(16'h55));
        tick();
        flush_i = 1'b0;
        q_if.fetch_valid_i  = 1'b0;
        q_if.issue_accept_i = 1'b0;
        checks++; if (occupancy !== 3'd0 || q_if.issue_valid_o !== 1'b0 || q_if.issue_instr_o !== 32'd0) begin errors++; $display("FAIL flush_empty occ=%0d valid=%0h instr=%08h exp=0/0/0", occupancy, q_if.issue_valid_o, q_if.issue_instr_o); end
        tick();
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL flush_dropped got=%0d exp=0", occupancy); end
        push_q(32'h00108133, 32'h410);
        checks++; if (q_if.issue_valid_o !== 1'b0) begin errors++; $display("FAIL flush_keeps_busy got=%0h exp=0", q_if.issue_valid_o); end
        writeback(5'd1);
        checks++; if (q_if.issue_valid_o !== 1'b1) begin errors++; $display("FAIL flush_release got=%0h exp=1", q_if.issue_valid_o); end
        pop_q();
        writeback(5'd2);
        push_q(32'h00048513, 32'h420);   // addi x10,x9,0: x9 must not be busy
        checks++; if (q_if.issue_valid_o !== 1'b1 || q_if.issue_ra_idx_o !== 5'd9) begin errors++; $display("FAIL flush_pop_ignored valid=%0h ra=%0d exp=1/9", q_if.issue_valid_o, q_if.issue_ra_idx_o); end
        pop_q();
        writeback(5'd10);
    endtask

    task automatic test_decode();
        logic [31:0] d_instr [8] = '{32'h025201B3, 32'h00000000, 32'h00032283, 32'h0063A023,
                                     32'h30501073, 32'h123452B7, 32'h0000007F, 32'h00500092};
        logic [1:0]  d_unit  [8] = '{2'd3, 2'd2, 2'd1, 2'd1, 2'd2, 2'd0, 2'd2, 2'd2};
        logic        d_ill   [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            push_q(d_instr[i], 32'h500 + 32'(4 * i));
            checks++; if (q_if.issue_valid_o !== 1'b1 || q_if.issue_unit_o !== d_unit[i] || q_if.issue_illegal_o !== d_ill[i]) begin errors++; $display("FAIL decode[%08h] valid=%0h unit=%0d ill=%0d exp=1/%0d/%0d", d_instr[i], q_if.issue_valid_o, q_if.issue_unit_o, q_if.issue_illegal_o, d_unit[i], d_ill[i]); end
            flush_i = 1'b1;
            tick();
            flush_i = 1'b0;
        end
        n_if.fetch_valid_i = 1'b1;
        n_if.fetch_instr_i = 32'h025201B3;
        n_if.fetch_pc_i    = 32'h580;
        $display("push(nm) instr=%08h", n_if.fetch_instr_i);
        tick();
        n_if.fetch_valid_i = 1'b0;
        checks++; if (n_if.issue_valid_o !== 1'b1 || n_if.issue_unit_o !== 2'd2 || n_if.issue_illegal_o !== 1'b1) begin errors++; $display("FAIL nm_mul valid=%0h unit=%0d ill=%0d exp=1/2/1", n_if.issue_valid_o, n_if.issue_unit_o, n_if.issue_illegal_o); end
        checks++; if (occupancy_n !== 2'd1) begin errors++; $display("FAIL nm_occ got=%0d exp=1", occupancy_n); end
        flush_i = 1'b1;
        n_if.fetch_valid_i = 1'b1;
        n_if.fetch_instr_i = 32'h00108133;
        tick();
        flush_i = 1'b0;
        tick();
        n_if.fetch_valid_i = 1'b0;
        checks++; if (n_if.issue_unit_o !== 2'd0 || n_if.issue_illegal_o !== 1'b0 || occupancy_n !== 2'd1) begin errors++; $display("FAIL nm_add unit=%0d ill=%0d occ=%0d exp=0/0/1", n_if.issue_unit_o, n_if.issue_illegal_o, occupancy_n); end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic test_set_wins();
        push_q(32'h00300313, 32'h600);   // addi x6,x0,3
        q_if.fetch_valid_i  = 1'b1;
        q_if.fetch_instr_i  = 32'h0063A023;   // sw x6,0(x7)
        q_if.fetch_pc_i     = 32'h604;
        q_if.issue_accept_i = 1'b1;
        wb_valid_i = 1'b1;
        wb_idx_i   = 5'd6;
        checks++; if (q_if.issue_valid_o !== 1'b1) begin errors++; $display("FAIL setwins_head got=%0h exp=1", q_if.issue_valid_o); end
        $display("issue instr=%08h with wb x6, push sw", q_if.issue_instr_o);
        tick();
        q_if.fetch_valid_i  = 1'b0;
        q_if.issue_accept_i = 1'b0;
        wb_valid_i = 1'b0;
        checks++; if (q_if.issue_instr_o !== 32'h0063A023 || q_if.issue_valid_o !== 1'b0) begin errors++; $display("FAIL setwins_stall instr=%08h valid=%0h exp=0063a023/0", q_if.issue_instr_o, q_if.issue_valid_o); end
        tick();
        checks++; if (q_if.issue_valid_o !== 1'b0) begin errors++; $display("FAIL setwins_hold got=%0h exp=0", q_if.issue_valid_o); end
        wb_valid_i = 1'b1;
        wb_idx_i   = 5'd6;
        checks++; if (q_if.issue_valid_o !== 1'b0) begin errors++; $display("FAIL setwins_no_bypass got=%0h exp=0", q_if.issue_valid_o); end
        tick();
        wb_valid_i = 1'b0;
        checks++; if (q_if.issue_valid_o !== 1'b1 || q_if.issue_unit_o !== 2'd1 || q_if.issue_rb_idx_o !== 5'd6 || q_if.issue_ra_idx_o !== 5'd7) begin errors++; $display("FAIL setwins_release valid=%0h unit=%0d rb=%0d ra=%0d exp=1/1/6/7", q_if.issue_valid_o, q_if.issue_unit_o, q_if.issue_rb_idx_o, q_if.issue_ra_idx_o); end
        pop_q();
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL setwins_empty got=%0d exp=0", occupancy); end
    endtask

    task automatic test_reset_mid();
        push_q(32'h00500093, 32'h700);
        pop_q();                          // x1 busy
        push_q(nop(1), 32'h704);
        push_q(nop(2), 32'h708);
        rst_i   = 1'b1;
        flush_i = 1'b1;
        q_if.fetch_valid_i  = 1'b1;
        q_if.fetch_instr_i  = nop(3);
        q_if.issue_accept_i = 1'b1;
        wb_valid_i = 1'b1;
        wb_idx_i   = 5'd5;
        tick();
        rst_i   = 1'b0;
        flush_i = 1'b0;
        q_if.fetch_valid_i  = 1'b0;
        q_if.issue_accept_i = 1'b0;
        wb_valid_i = 1'b0;
        checks++; if (occupancy !== 3'd0 || q_if.issue_valid_o !== 1'b0 || q_if.fetch_accept_o !== 1'b1) begin errors++; $display("FAIL midreset_state occ=%0d valid=%0h accept=%0h exp=0/0/1", occupancy, q_if.issue_valid_o, q_if.fetch_accept_o); end
        push_q(32'h00108133, 32'h710);
        checks++; if (q_if.issue_valid_o !== 1'b1) begin errors++; $display("FAIL midreset_busy_clear got=%0h exp=1", q_if.issue_valid_o); end
        pop_q();
    endtask

    initial begin
        rst_i      = 1'b1;
        flush_i    = 1'b0;
        wb_valid_i = 1'b0;
        wb_idx_i   = 5'd0;
        q_if.fetch_valid_i  = 1'b0;
        q_if.fetch_instr_i  = 32'd0;
        q_if.fetch_pc_i     = 32'd0;
        q_if.issue_accept_i = 1'b0;
        n_if.fetch_valid_i  = 1'b0;
        n_if.fetch_instr_i  = 32'd0;
        n_if.fetch_pc_i     = 32'd0;
        n_if.issue_accept_i = 1'b0;

        test_reset();
        test_basic();
        test_hazard();
        test_full_wrap();
        test_flush();
        test_decode();
        test_set_wins();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/riscv_decode_queue.md
Name: riscv_decode_queue

Overview:
Parametrised successor to the single-register decode stage. It sits between fetch and the execution units. Each instruction is pre-decoded at push time into a DEPTH-entry instruction queue. A register scoreboard holds back issue on RAW and WAW hazards, and the queue is flushed on a branch.

Parameters:
DEPTH, 2, number of queue entries (power of two, >=2)
SUPPORT_MULDIV, 1, 1: M-extension ops route to MULDIV; 0: they decode as illegal

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
fetch_valid_i  in  1  fetch presents an instruction
fetch_instr_i  in  32  instruction word
fetch_pc_i  in  32  instruction PC
fetch_accept_o  out  1  queue can take an instruction this cycle
flush_i  in  1  branch/CSR redirect; discard all queued instructions
issue_valid_o  out  1  head entry is hazard-free and presented
issue_accept_i  in  1  target unit takes the head entry
issue_instr_o  out  32  head instruction word
issue_pc_o  out  32  head PC
issue_unit_o  out  2  0=EXEC 1=LSU 2=CSR 3=MULDIV
issue_illegal_o  out  1  head is illegal; unit field = CSR
issue_rd_idx_o  out  5  rd field
issue_ra_idx_o  out  5  rs1 field
issue_rb_idx_o  out  5  rs2 field
wb_valid_i  in  1  a writeback completes this cycle
wb_idx_i  in  5  register written back
occupancy_o  out  $clog2(DEPTH+1)  queued entry count

Behaviour:
- Reset: queue empty, all pointers 0, occupancy_o=0, scoreboard all clear.
  - Outputs under reset: issue_valid_o=0, fetch_accept_o=1, issue_* data fields 0.
- Push: occurs when fetch_valid_i && fetch_accept_o && !flush_i.
  - fetch_accept_o = !full, computed from registered state only.
  - A push while full is impossible.
  - The pushed data is stored in the tail entry together with pre-decode fields: unit, illegal, uses_ra, uses_rb, writes_rd.
- Pre-decode by opcode:
  - 0110011 with funct7=0000001 -> MULDIV if SUPPORT_MULDIV, else illegal.
  - 0110011, 0010011, 1100011, 1101111, 1100111, 0110111, 0010111 -> EXEC.
  - 0000011, 0100011 -> LSU.
  - 1110011 -> CSR.
  - Anything else, or instr[1:0]!=11 -> illegal: unit=CSR, illegal=1.
- Operand usage:
  - uses_ra: all except 0110111, 0010111, 1101111.
  - uses_rb: 0110011, 1100011, 0100011.
  - writes_rd: all except 1100011 and 0100011, and only when rd!=0.
  - Illegal entries: uses_ra, uses_rb and writes_rd all 0.
- Hazard: asserted when the head entry has any of:
  - uses_ra && ra!=0 && busy[ra];
  - uses_rb && rb!=0 && busy[rb];
  - writes_rd && busy[rd].
- Issue handshake:
  - issue_valid_o = !empty && !hazard, combinational from registered state.
  - issue_* data fields always reflect the head entry, and are 0 when empty.
  - Pop occurs when issue_valid_o && issue_accept_i.
- Latency: an instruction pushed in cycle N can issue at the earliest in cycle N+1. Push and pop may occur in the same cycle; occupancy is then unchanged.
- Scoreboard:
  - On pop with writes_rd, set busy[rd].
  - On wb_valid_i with wb_idx_i!=0, clear busy[wb_idx_i].
  - If the same index is set and cleared in one cycle, set wins.
  - A writeback releases a stalled head one cycle later; there is no bypass into the hazard check.
  - busy[0] is never set.
- Flush:
  - The next state is empty; a push in the same cycle is dropped and a pop in the same cycle is ignored.
  - The scoreboard is NOT cleared: instructions already issued still write back.
  - issue_valid_o=0 in the cycle after the flush.
- Pointer wrap: log2(DEPTH) bits wrapping modulo DEPTH. Full/empty come from the occupancy counter.
- Reset mid-operation overrides flush, push, pop and writeback.

Test Plan:
1. Reset, then push addi x1,x0,5 (0x00500093, PC 0x100) -> next cycle issue_valid_o=1, unit=0, rd=1, pc=0x100; accept -> busy[1]=1, occupancy 0.
2. Push add x2,x1,x1 while busy[1] -> issue_valid_o=0. Assert wb_valid_i with idx=1 -> issue_valid_o=1 in the following cycle.
3. Push DEPTH+1 instructions with issue_accept_i=0 -> fetch_accept_o=0 once occupancy=DEPTH. Then drain -> all issue in order; pointers wrap correctly across 3*DEPTH pushes.
4. Queue holds 2 entries; flush_i and a push in the same cycle -> occupancy 0 next cycle, pushed instruction never issues, existing busy bits unchanged.
5. Push mul x3,x4,x5 (0x025201B3) -> unit=3 with SUPPORT_MULDIV=1; with SUPPORT_MULDIV=0 -> unit=2, issue_illegal_o=1. Push 0x00000000 -> illegal=1.
6. Pop writes x6 while wb_valid_i idx=6 in the same cycle -> busy[6]=1 afterwards. Store sw x6,0(x7) behind it waits for the next writeback to x6.
